midi_rx: RTL

MIDI_RX -- requirements
Module: midi_rx

---
 rtl/midi_rx.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/midi_rx.sv
// MIDI serial receiver (8N1, LSB first) with a first-word-fall-through byte FIFO
// and sticky overrun / framing error flags for an MPU-401 style status port.
module midi_rx #(
  parameter int CLK_DIV = 800,
  parameter int FIFO_AW = 4
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       midi_in,
  input  logic       rd,
  input  logic       clr_err,
  output logic [7:0] dout,
  output logic       rx_empty,
  output logic       rx_full,
  output logic       overrun,
  output logic       frame_err
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [15:0]        DIV_FULL  = 16'(CLK_DIV);
  localparam logic [15:0]        DIV_HALF  = 16'(CLK_DIV / 2);
  localparam logic [FIFO_AW-1:0] PTR_ONE   = 1;
  localparam logic [FIFO_AW:0]   CNT_ONE   = 1;
  localparam logic [FIFO_AW:0]   CNT_DEPTH = DEPTH;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t      state, state_d;
  logic        sync_p0, sync_p1;
  logic        line;
  logic [15:0] timer, timer_d;
  logic [2:0]  idx, idx_d;
  logic [7:0]  shreg, shreg_d;
  logic        expire;
  logic        push, frame_set;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               do_rd, do_wr;

  // Stage p0/p1: two-flop synchronizer; idle-high line resets to 1
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= midi_in;
      sync_p1 <= sync_p0;
    end
  end

  assign line = sync_p1;

  // A load of N makes the timer expire N cycles later
  assign expire = (timer == 16'd1);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      timer <= 16'd0;
      idx   <= 3'd0;
    end else begin
      state <= state_d;
      timer <= timer_d;
      idx   <= idx_d;
    end
  end

  always_ff @(posedge clk_sys) begin
    shreg <= shreg_d;
  end

  always_comb begin
    state_d   = state;
    timer_d   = timer;
    idx_d     = idx;
    shreg_d   = shreg;
    push      = 1'b0;
    frame_set = 1'b0;
    case (state)
      IDLE: begin
        if (!line) begin
          timer_d = DIV_HALF;
          state_d = START;
        end
      end
      START: begin
        timer_d = timer - 16'd1;
        if (expire) begin
          if (line) begin
            state_d = IDLE;
          end else begin
            timer_d = DIV_FULL;
            idx_d   = 3'd0;
            state_d = DATA;
          end
        end
      end
      DATA: begin
        timer_d = timer - 16'd1;
        if (expire) begin
          shreg_d[idx] = line;
          timer_d      = DIV_FULL;
          if (idx == 3'd7) state_d = STOP;
          else             idx_d   = idx + 3'd1;
        end
      end
      STOP: begin
        timer_d = timer - 16'd1;
        if (expire) begin
          if (line) begin
            push    = 1'b1;
            state_d = IDLE;
          end else begin
            frame_set = 1'b1;
            state_d   = BREAK;
          end
        end
      end
      BREAK: begin
        if (line) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO: a pop frees the head slot, so a push into a full FIFO is accepted alongside it
  assign rx_empty = (count == '0);
  assign rx_full  = (count == CNT_DEPTH);
  assign do_rd    = rd & ~rx_empty;
  assign do_wr    = push & (~rx_full | do_rd);
  assign dout     = rx_empty ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge clk_sys) begin
    if (do_wr) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_wr, do_rd})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Sticky flags: a set event outranks a simultaneous clear
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (push & ~do_wr) overrun <= 1'b1;
      else if (clr_err)  overrun <= 1'b0;
      if (frame_set)     frame_err <= 1'b1;
      else if (clr_err)  frame_err <= 1'b0;
    end
  end

endmodule
